// File: rtl/booth_pkg.sv
// Shared types and defaults for the round-robin Booth multiplier scheduler.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_W       = 8;
  localparam int unsigned DEF_TIMEOUT = 64;

  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority select: first asserted req at ptr, ptr+1, ... mod N_REQ.
module rr_pick
  import booth_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned ID_W  = $clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  id
);

  localparam int unsigned SW = ID_W + 1;

  logic [N_REQ-1:0] rot;
  logic [SW-1:0]    sum;

  // Rotating the doubled vector puts req[ptr] at bit 0, so a plain low-first scan is round-robin.
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    any = 1'b0;
    id  = '0;
    sum = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + SW'(i);
        if (sum >= SW'(N_REQ)) begin
          sum = sum - SW'(N_REQ);
        end
        id = sum[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one sequential Booth multiplier among N_REQ requesters.
// Optional WAIT watchdog enabled by defining BOOTH_SCHED_TIMEOUT_EN.
module booth_mul_sched
  import booth_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*W-1:0]       op_a,
  input  logic [N_REQ*W-1:0]       op_b,
  output logic [N_REQ-1:0]         ack,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [prod_w(W)-1:0]     rsp_prod,
  output logic                     rsp_err,
  output logic                     mul_start,
  output logic [W-1:0]             mul_a,
  output logic [W-1:0]             mul_b,
  input  logic                     mul_done,
  input  logic [prod_w(W)-1:0]     mul_prod
);

  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam int unsigned PW   = prod_w(W);

  if (N_REQ < 2 || TIMEOUT < 1) begin : g_cfg_check
    $error("booth_mul_sched: N_REQ must be >= 2 and TIMEOUT >= 1");
  end

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   win_q, win_d;
  logic              arm_q, arm_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              mul_start_q, mul_start_d;
  logic [W-1:0]      mul_a_q, mul_a_d;
  logic [W-1:0]      mul_b_q, mul_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [PW-1:0]     rsp_prod_q, rsp_prod_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timed_out;

  logic              pick_any;
  logic [ID_W-1:0]   pick_id;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .id  (pick_id)
  );

`ifdef BOOTH_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_comb begin
    cnt_d     = '0;
    timed_out = 1'b0;
    if (state_q == WAIT) begin
      cnt_d     = cnt_q + 1'b1;
      timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    arm_d       = arm_q;
    ack_d       = '0;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = LOAD;
          win_d       = pick_id;
          mul_a_d     = op_a[pick_id*W +: W];
          mul_b_d     = op_b[pick_id*W +: W];
          ack_d       = N_REQ'(1) << pick_id;
          mul_start_d = 1'b1;
          arm_d       = 1'b0;
        end
      end
      LOAD: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A done level still high from the previous operation is ignored until seen low once.
        if (!mul_done) begin
          arm_d = 1'b1;
        end
        if (arm_q && mul_done) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = win_q;
          rsp_prod_d  = mul_prod;
          rsp_err_d   = 1'b0;
        end else if (timed_out) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = win_q;
          rsp_prod_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = (win_q == ID_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      arm_q       <= 1'b0;
      ack_q       <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      arm_q       <= arm_d;
      ack_q       <= ack_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign ack       = ack_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched with a behavioural sequential-multiplier stand-in.
module tb_booth_mul_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  op_a;
  logic [N*W-1:0]  op_b;
  logic [N-1:0]    ack;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [PW-1:0]   rsp_prod;
  logic            rsp_err;
  logic            mul_start;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic            mul_done;
  logic [PW-1:0]   mul_prod;

  int n_vec   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int rsp_cnt = 0;

  int stale_hold = 0;
  int lat_low    = 2;
  bit stuck_low  = 0;

  logic [PW-1:0] rr_prod [4] = '{16'hFFFE, 16'hFFFA, 16'hFFF4, 16'hFFEC};

  booth_mul_sched #(
    .N_REQ   (4),
    .W       (8),
    .TIMEOUT (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(posedge clk) if (rsp_valid) rsp_cnt++;

  // Multiplier stand-in: done keeps its old level for stale_hold cycles after start,
  // goes low for lat_low cycles, then rises with the product and stays high.
  initial begin : mul_model
    logic signed [W-1:0] pa, pb;
    int hold_left, lat_left;
    bit busy;
    pa = '0; pb = '0; hold_left = 0; lat_left = 0; busy = 0;
    mul_done = 1'b0;
    mul_prod = '0;
    forever begin
      @(posedge clk); #1;
      if (mul_start) begin
        pa = mul_a; pb = mul_b;
        hold_left = stale_hold; lat_left = lat_low; busy = 1;
      end else if (busy) begin
        if (hold_left > 0) hold_left--;
        else if (stuck_low) mul_done = 1'b0;
        else if (lat_left > 0) begin
          mul_done = 1'b0;
          lat_left--;
        end else begin
          mul_done = 1'b1;
          mul_prod = pa * pb;
          busy = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic wait_ack(input int budget, output logic [N-1:0] a, output int c);
    bit found;
    found = 0; a = '0; c = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        found = 1; a = ack; c = cyc;
      end
    end
    check("ack_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_rsp(input int budget, output logic [1:0] id, output logic [PW-1:0] prod,
                          output logic err, output int c);
    bit found;
    found = 0; id = '0; prod = '0; err = 1'b0; c = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1; id = rsp_id; prod = rsp_prod; err = rsp_err; c = cyc;
      end
    end
    check("rsp_seen", 32'(found), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [N-1:0]  a;
    logic [1:0]    id;
    logic [PW-1:0] prod;
    logic          err;
    int            c0, c1, n0;

    rst = 1'b1; req = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_prod", 32'(rsp_prod), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request: 7 * -3, done 10 cycles after start.
    lat_low = 9;
    set_op(0, 8'd7, 8'hFD);
    req = 4'b0001;
    wait_ack(10, a, c0);
    check("single_ack", 32'(a), 32'h1);
    check("single_start", 32'(mul_start), 32'd1);
    check("single_mul_a", 32'(mul_a), 32'h07);
    check("single_mul_b", 32'(mul_b), 32'hFD);
    req = '0;
    @(negedge clk);
    check("single_ack_pulse", 32'(ack), 32'd0);
    check("single_start_pulse", 32'(mul_start), 32'd0);
    n0 = rsp_cnt;
    wait_rsp(40, id, prod, err, c1);
    check("single_id", 32'(id), 32'd0);
    check("single_prod", 32'(prod), 32'hFFEB);
    check("single_err", 32'(err), 32'd0);
    check("single_latency", 32'(c1 - c0), 32'd11);
    check("single_mul_a_stable", 32'(mul_a), 32'h07);
    @(negedge clk);
    check("single_rsp_pulse", 32'(rsp_valid), 32'd0);
    check("single_rsp_count", 32'(rsp_cnt - n0), 32'd1);

    // All four requesting from reset: grants 0,1,2,3,0.
    rst = 1'b1;
    lat_low = 2;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 2), 8'(-(i + 1)));
    req = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(10, a, c0);
      check("rr_ack", 32'(a), 32'(1 << (k % 4)));
      if (k == 4) req = '0;
      wait_rsp(20, id, prod, err, c1);
      check("rr_id", 32'(id), 32'(k % 4));
      check("rr_prod", 32'(prod), 32'(rr_prod[k % 4]));
    end

    // Sticky done: still high at LOAD, low 3 cycles, then high with the new product.
    stale_hold = 1;
    lat_low = 3;
    set_op(1, 8'hFB, 8'h06);
    req = 4'b0010;
    wait_ack(10, a, c0);
    check("sticky_ack", 32'(a), 32'h2);
    req = '0;
    n0 = rsp_cnt;
    wait_rsp(30, id, prod, err, c1);
    check("sticky_id", 32'(id), 32'd1);
    check("sticky_prod", 32'(prod), 32'hFFE2);
    check("sticky_latency", 32'(c1 - c0), 32'd6);
    repeat (10) @(negedge clk);
    check("sticky_rsp_count", 32'(rsp_cnt - n0), 32'd1);
    stale_hold = 0;

    // Reset while in WAIT with req[2] held: operation dropped, re-arbitrated.
    lat_low = 5;
    set_op(2, 8'd9, 8'hF7);
    req = 4'b0100;
    wait_ack(10, a, c0);
    check("rstwait_ack", 32'(a), 32'h4);
    n0 = rsp_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstwait_ack_in_rst", 32'(ack), 32'd0);
    check("rstwait_valid_in_rst", 32'(rsp_valid), 32'd0);
    check("rstwait_mul_a_in_rst", 32'(mul_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstwait_ack_after", 32'(ack), 32'h4);
    check("rstwait_no_rsp", 32'(rsp_cnt - n0), 32'd0);
    req = '0;
    wait_rsp(30, id, prod, err, c1);
    check("rstwait_id", 32'(id), 32'd2);
    check("rstwait_prod", 32'(prod), 32'hFFAF);

    // Operand extremes.
    lat_low = 2;
    set_op(0, 8'h80, 8'h80);
    req = 4'b0001;
    wait_ack(10, a, c0);
    req = '0;
    wait_rsp(20, id, prod, err, c1);
    check("ext_mm_id", 32'(id), 32'd0);
    check("ext_mm_prod", 32'(prod), 32'h4000);
    set_op(3, 8'h7F, 8'h80);
    req = 4'b1000;
    wait_ack(10, a, c0);
    check("ext_pm_ack", 32'(a), 32'h8);
    req = '0;
    wait_rsp(20, id, prod, err, c1);
    check("ext_pm_id", 32'(id), 32'd3);
    check("ext_pm_prod", 32'(prod), 32'hC080);
    check("ext_pm_err", 32'(err), 32'd0);

`ifdef BOOTH_SCHED_TIMEOUT_EN
    // Done stuck low: abort after 64 WAIT cycles, then a normal operation.
    stuck_low = 1;
    set_op(0, 8'd5, 8'd5);
    req = 4'b0001;
    wait_ack(10, a, c0);
    req = '0;
    wait_rsp(100, id, prod, err, c1);
    check("tmo_id", 32'(id), 32'd0);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_prod", 32'(prod), 32'd0);
    check("tmo_latency", 32'(c1 - c0), 32'd65);
    stuck_low = 0;
    set_op(1, 8'd2, 8'd3);
    req = 4'b0010;
    wait_ack(10, a, c0);
    check("tmo_next_ack", 32'(a), 32'h2);
    req = '0;
    wait_rsp(20, id, prod, err, c1);
    check("tmo_next_err", 32'(err), 32'd0);
    check("tmo_next_prod", 32'(prod), 32'd6);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
